// File: rtl/tick_scheduler.sv
// Programmable period tick generator with one-shot/pause/stop control and a free-running digit-scan divider.
// Ticks follow the terminal count by one cycle; all outputs are registered.
module tick_scheduler #(
  parameter int          CNT_W      = 25,
  parameter int unsigned DEF_PERIOD = 24999999,
  parameter int          SCAN_DIV   = 10000,
  parameter int          DIGITS     = 4,
  localparam int         SEL_W      = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic             cfg_oneshot,
  input  logic             start,
  input  logic             stop,
  input  logic             hold,
  output logic             tick,
  output logic             tick_toggle,
  output logic             busy,
  output logic             done,
  output logic             scan_tick,
  output logic [SEL_W-1:0] scan_sel
);

  localparam int SCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] period_reg;
  logic [CNT_W-1:0] cnt;
  logic             oneshot_reg;
  logic             tc_pend;
  logic [SCW-1:0]   scan_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      period_reg  <= CNT_W'(DEF_PERIOD);
      oneshot_reg <= 1'b0;
    end else if (cfg_valid && cfg_ready) begin
      period_reg  <= cfg_period;
      oneshot_reg <= cfg_oneshot;
    end
  end

  // tc_pend marks the terminal count; the tick itself is issued one cycle later
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      tc_pend     <= 1'b0;
      tick        <= 1'b0;
      tick_toggle <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      cfg_ready   <= 1'b1;
    end else if (stop) begin
      state       <= IDLE;
      cnt         <= '0;
      tc_pend     <= 1'b0;
      tick        <= 1'b0;
      tick_toggle <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      cfg_ready   <= 1'b1;
    end else begin
      tick <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= RUN;
            cnt       <= '0;
            tc_pend   <= 1'b0;
            busy      <= 1'b1;
            cfg_ready <= 1'b0;
          end
        end
        RUN, PAUSE: begin
          if (tc_pend) begin
            tick        <= 1'b1;
            tick_toggle <= ~tick_toggle;
          end
          if (tc_pend && oneshot_reg) begin
            state     <= DONE;
            tc_pend   <= 1'b0;
            done      <= 1'b1;
            busy      <= 1'b0;
            cfg_ready <= 1'b1;
          end else if (hold) begin
            state   <= PAUSE;
            tc_pend <= 1'b0;
          end else begin
            // leaving PAUSE counts in the same cycle so a hold of N cycles stretches by exactly N
            state   <= RUN;
            tc_pend <= (cnt == period_reg);
            cnt     <= (cnt == period_reg) ? '0 : cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt  <= '0;
      scan_tick <= 1'b0;
      scan_sel  <= '0;
    end else if (scan_cnt == SCW'(SCAN_DIV - 1)) begin
      scan_cnt  <= '0;
      scan_tick <= 1'b1;
      scan_sel  <= (scan_sel == SEL_W'(DIGITS - 1)) ? '0 : scan_sel + SEL_W'(1);
    end else begin
      scan_cnt  <= scan_cnt + SCW'(1);
      scan_tick <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tick_scheduler.sv
// Bench for tick_scheduler: expected tick events are queued at start time and matched as ticks appear.
module tb_tick_scheduler;

  localparam int CNT_W = 8;

  typedef struct {
    int   cyc;
    logic tog;
    logic dn;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [CNT_W-1:0] cfg_period = '0;
  logic             cfg_oneshot = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             hold = 1'b0;
  logic             tick;
  logic             tick_toggle;
  logic             busy;
  logic             done;
  logic             scan_tick;
  logic [1:0]       scan_sel;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  logic exp_tog = 1'b0;
  exp_t exp_q[$];

  tick_scheduler #(
    .CNT_W(CNT_W), .DEF_PERIOD(200), .SCAN_DIV(4), .DIGITS(4)
  ) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_period(cfg_period), .cfg_oneshot(cfg_oneshot), .start(start),
    .stop(stop), .hold(hold), .tick(tick), .tick_toggle(tick_toggle),
    .busy(busy), .done(done), .scan_tick(scan_tick), .scan_sel(scan_sel)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Sampled at negedge: cyc equals the number of the edge that produced the outputs
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (done === 1'b1 && tick !== 1'b1) begin
        checks++;
        errors++;
        $display("FAIL done_without_tick cyc=%0d done=%b tick=%b, required tick=1", cyc, done, tick);
      end
      if (tick === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_tick cyc=%0d, required no tick", cyc);
        end else begin
          e = exp_q.pop_front();
          if (cyc !== e.cyc || tick_toggle !== e.tog || done !== e.dn) begin
            errors++;
            $display("FAIL tick_event got cyc=%0d toggle=%b done=%b, required cyc=%0d toggle=%b done=%b",
                     cyc, tick_toggle, done, e.cyc, e.tog, e.dn);
          end
        end
      end
    end
  end

  task automatic push_tick(input int c, input logic dn);
    exp_tog = ~exp_tog;
    exp_q.push_back('{c, exp_tog, dn});
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic cfg_load(input int p, input logic os);
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL cfg_ready_idle got %b required 1", cfg_ready);
    end
    cfg_valid   = 1'b1;
    cfg_period  = CNT_W'(p);
    cfg_oneshot = os;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    exp_tog = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({tick, tick_toggle, busy, done, scan_tick, scan_sel, cfg_ready} !== 8'b0000_0001) begin
      errors++;
      $display("FAIL reset_outputs got tick=%b tog=%b busy=%b done=%b scan_tick=%b sel=%0d rdy=%b, required all 0 and rdy=1",
               tick, tick_toggle, busy, done, scan_tick, scan_sel, cfg_ready);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_scan();
    int r;
    logic [1:0] exp_sel;
    rst = 1'b1;
    @(negedge clk);
    r = cyc;
    rst = 1'b0;
    for (int d = 1; d <= 20; d++) begin
      @(negedge clk);
      exp_sel = 2'(((cyc - r) / 4) % 4);
      checks++;
      if (scan_tick !== ((cyc - r) % 4 == 0) || scan_sel !== exp_sel) begin
        errors++;
        $display("FAIL scan_seq d=%0d got tick=%b sel=%0d, required tick=%b sel=%0d",
                 cyc - r, scan_tick, scan_sel, ((cyc - r) % 4 == 0), exp_sel);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (scan_sel !== 2'd0 || scan_tick !== 1'b0) begin
      errors++;
      $display("FAIL scan_rst got sel=%0d tick=%b, required sel=0 tick=0", scan_sel, scan_tick);
    end
  endtask

  task automatic test_periodic();
    int k;
    cfg_load(3, 1'b0);
    start = 1'b1;
    k = cyc + 1;
    push_tick(k + 5, 1'b0);
    push_tick(k + 9, 1'b0);
    push_tick(k + 13, 1'b0);
    @(negedge clk);
    start = 1'b0;
    while (cyc < k + 14) begin
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL periodic_busy cyc=%0d got %b required 1", cyc, busy);
      end
      @(negedge clk);
    end
    do_stop();
    checks++;
    if (busy !== 1'b0 || tick_toggle !== 1'b0 || cfg_ready !== 1'b1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL periodic_end got busy=%b tog=%b rdy=%b pending=%0d, required 0 0 1 0",
               busy, tick_toggle, cfg_ready, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_oneshot();
    int k;
    cfg_load(2, 1'b1);
    start = 1'b1;
    k = cyc + 1;
    push_tick(k + 4, 1'b1);
    @(negedge clk);
    start = 1'b0;
    wait_until(k + 15);
    checks++;
    if (busy !== 1'b0 || cfg_ready !== 1'b1 || done !== 1'b0 || tick_toggle !== 1'b1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL oneshot_end got busy=%b rdy=%b done=%b tog=%b pending=%0d, required 0 1 0 1 0",
               busy, cfg_ready, done, tick_toggle, exp_q.size());
    end
    exp_q.delete();
    do_stop();
  endtask

  task automatic test_hold();
    int k;
    cfg_load(4, 1'b0);
    start = 1'b1;
    k = cyc + 1;
    push_tick(k + 6, 1'b0);
    push_tick(k + 14, 1'b0);
    push_tick(k + 19, 1'b0);
    @(negedge clk);
    start = 1'b0;
    wait_until(k + 7);
    hold = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL hold_busy got %b required 1", busy);
    end
    wait_until(k + 10);
    hold = 1'b0;
    wait_until(k + 21);
    do_stop();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL hold_pending got %0d ticks outstanding required 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_stop_tc();
    int k;
    cfg_load(3, 1'b0);
    start = 1'b1;
    k = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    wait_until(k + 1);
    checks++;
    if (cfg_ready !== 1'b0) begin
      errors++;
      $display("FAIL run_cfg_ready got %b required 0", cfg_ready);
    end
    cfg_valid  = 1'b1;
    cfg_period = CNT_W'(1);
    wait_until(k + 3);
    cfg_valid = 1'b0;
    wait_until(k + 4);
    do_stop();
    checks++;
    if (tick !== 1'b0 || busy !== 1'b0 || tick_toggle !== 1'b0 || cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL stop_tc got tick=%b busy=%b tog=%b rdy=%b, required 0 0 0 1",
               tick, busy, tick_toggle, cfg_ready);
    end
    start = 1'b1;
    k = cyc + 1;
    push_tick(k + 5, 1'b0);
    @(negedge clk);
    start = 1'b0;
    wait_until(k + 7);
    do_stop();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL period_kept got %0d ticks outstanding required 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    int k;
    cfg_valid  = 1'b1;
    cfg_period = '0;
    cfg_oneshot = 1'b0;
    start = 1'b1;
    k = cyc + 1;
    for (int i = 2; i <= 7; i++) push_tick(k + i, 1'b0);
    @(negedge clk);
    cfg_valid = 1'b0;
    start = 1'b0;
    wait_until(k + 7);
    do_stop();
    checks++;
    if (exp_q.size() != 0 || tick_toggle !== 1'b0 || tick !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back got pending=%0d tog=%b tick=%b required 0 0 0",
               exp_q.size(), tick_toggle, tick);
    end
    exp_q.delete();
  endtask

  task automatic test_rst_midrun();
    int k;
    cfg_load(2, 1'b0);
    start = 1'b1;
    k = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    wait_until(k + 3);
    rst = 1'b1;
    start = 1'b1;
    cfg_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    cfg_valid = 1'b0;
    exp_tog = 1'b0;
    checks++;
    if (tick !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || tick_toggle !== 1'b0 || cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_midrun got tick=%b done=%b busy=%b tog=%b rdy=%b, required 0 0 0 0 1",
               tick, done, busy, tick_toggle, cfg_ready);
    end
    // the default period (200) must be back: no tick within 30 cycles of a fresh start
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_default_run got busy=%b required 1", busy);
    end
    do_stop();
  endtask

  initial begin
    test_reset();
    test_scan();
    test_periodic();
    test_oneshot();
    test_hold();
    test_stop_tc();
    test_back_to_back();
    test_rst_midrun();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
